// File: rtl/e203_itcm_banked_ram_if.sv
// Command/response channel bundle for one ITCM port (IFU fetch or LSU).
// The requester uses the master modport and the banked RAM uses the slave modport.
interface e203_itcm_banked_ram_if #(
  parameter int AW = 16,
  parameter int DW = 64,
  parameter int MW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/e203_itcm_banked_ram.sv
// Dual-port (IFU = A, LSU = B) ITCM storage over NBANK word-interleaved banks.
// Each bank has a round-robin arbiter for same-bank conflicts, responses are
// registered with one cycle of latency, and idle banks drop into light sleep.
module e203_itcm_banked_ram #(
  parameter int AW      = 16,
  parameter int DW      = 64,
  parameter int MW      = 8,
  parameter int NBANK   = 2,
  parameter int IDLE_LS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sd,
  input  logic                 ds,
  e203_itcm_banked_ram_if.slave a,
  e203_itcm_banked_ram_if.slave b,
  output logic [NBANK-1:0]     ls_status
);

  localparam int KW    = $clog2(NBANK);        // bank-select address bits
  localparam int BW    = (KW > 0) ? KW : 1;    // width of a bank index signal
  localparam int RW    = AW - KW;              // row bits inside one bank
  localparam int DEPTH = 1 << RW;
  localparam int LW    = DW / MW;              // data bits per mask lane

  // Per-port signals, index 0 = port A, index 1 = port B.
  logic [1:0]    valid, read, rsp_ready;
  logic [1:0]    slot_free, elig, contend, ready, accept;
  logic          same_bank;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [MW-1:0] wmask [2];
  logic [BW-1:0] bk    [2];

  // Response registers.
  logic [1:0]    rsp_valid_q, fresh_q, rd_q;
  logic [BW-1:0] rsp_bk_q [2];
  logic [DW-1:0] hold_q   [2];
  logic [DW-1:0] rdata    [2];

  // Bank-side signals.
  logic [NBANK-1:0] cs, we, conflict, req_any, fav_a_q;
  logic [RW-1:0]    row  [NBANK];
  logic [DW-1:0]    din  [NBANK];
  logic [MW-1:0]    wem  [NBANK];
  logic [DW-1:0]    dout [NBANK];

  function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] ad);
    if (KW == 0) return '0;
    return ad[BW-1:0];
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [AW-1:0] ad);
    return RW'(ad >> KW);
  endfunction

  assign valid[0]     = a.cmd_valid;
  assign valid[1]     = b.cmd_valid;
  assign read[0]      = a.cmd_read;
  assign read[1]      = b.cmd_read;
  assign addr[0]      = a.cmd_addr;
  assign addr[1]      = b.cmd_addr;
  assign wdata[0]     = a.cmd_wdata;
  assign wdata[1]     = b.cmd_wdata;
  assign wmask[0]     = a.cmd_wmask;
  assign wmask[1]     = b.cmd_wmask;
  assign rsp_ready[0] = a.rsp_ready;
  assign rsp_ready[1] = b.rsp_ready;
  assign bk[0]        = bank_of(a.cmd_addr);
  assign bk[1]        = bank_of(b.cmd_addr);

  assign a.cmd_ready  = ready[0];
  assign b.cmd_ready  = ready[1];
  assign a.rsp_valid  = rsp_valid_q[0];
  assign b.rsp_valid  = rsp_valid_q[1];
  assign a.rsp_rdata  = rdata[0];
  assign b.rsp_rdata  = rdata[1];

  // Port readiness: a port only contends for its bank when nothing of its own
  // (full response slot, sleeping bank, shutdown) blocks it.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      slot_free[p] = ~rsp_valid_q[p] | rsp_ready[p];
      elig[p]      = ~sd & slot_free[p] & ~ls_status[bk[p]];
      contend[p]   = valid[p] & elig[p];
    end
    same_bank = (bk[0] == bk[1]);
    ready[0]  = elig[0] & (~(contend[1] & same_bank) |  fav_a_q[bk[0]]);
    ready[1]  = elig[1] & (~(contend[0] & same_bank) | ~fav_a_q[bk[1]]);
    accept    = valid & ready;
  end

  // Route the accepted command of each port to its bank.
  always_comb begin
    for (int k = 0; k < NBANK; k++) begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cs[k]       = 1'b0;
      we[k]       = 1'b0;
      row[k]      = '0;
      din[k]      = '0;
      wem[k]      = '0;
      conflict[k] = contend[0] & contend[1] & (bk[0] == BW'(k)) & (bk[1] == BW'(k));
      req_any[k]  = (valid[0] & (bk[0] == BW'(k))) | (valid[1] & (bk[1] == BW'(k)));
      for (int p = 0; p < 2; p++) begin
        if (accept[p] && (bk[p] == BW'(k))) begin
          cs[k]  = 1'b1;
          we[k]  = ~read[p];
          row[k] = row_of(addr[p]);
          din[k] = wdata[p];
          wem[k] = wmask[p];
        end
      end
    end
  end

  // Round-robin pointers: a bank hands priority to the other port only after a real conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fav_a_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      fav_a_q <= fav_a_q ^ conflict;
    end
  end

  // Bank storage with byte-lane write mask and a registered read port.
  for (genvar k = 0; k < NBANK; k++) begin : g_bank
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout_q;

    // Synchronous bank access; a bank gated by sd, ds or ls ignores the strobe.
    always_ff @(posedge clk) begin
      // NOTE: storage and its read register are deliberately not reset; contents are defined only by writes.
      if (cs[k] && !(sd || ds || ls_status[k])) begin
        if (we[k]) begin
          for (int m = 0; m < MW; m++) begin
            if (wem[k][m]) mem[row[k]][m*LW +: LW] <= din[k][m*LW +: LW];
          end
        end else begin
          dout_q <= mem[row[k]];
        end
      end
    end

    assign dout[k] = dout_q;
  end

  // Response data: live bank output in the first response cycle, held copy afterwards.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if (fresh_q[p]) rdata[p] = rd_q[p] ? dout[rsp_bk_q[p]] : '0;
      else            rdata[p] = hold_q[p];
    end
  end

  // Response slot per port: fills on accept, drains on rsp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      fresh_q     <= '0;
      rd_q        <= '0;
      for (int p = 0; p < 2; p++) begin
        rsp_bk_q[p] <= '0;
        hold_q[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (accept[p]) begin
          rsp_valid_q[p] <= 1'b1;
          fresh_q[p]     <= 1'b1;
          rd_q[p]        <= read[p];
          rsp_bk_q[p]    <= bk[p];
        end else begin
          fresh_q[p] <= 1'b0;
          if (rsp_ready[p]) rsp_valid_q[p] <= 1'b0;
        end
        if (fresh_q[p]) hold_q[p] <= rdata[p];
      end
    end
  end

  if (IDLE_LS > 0) begin : g_ls
    localparam int CW = $clog2(IDLE_LS + 1);

    for (genvar k = 0; k < NBANK; k++) begin : g_cnt
      logic [CW-1:0] cnt_q, cnt_n;
      logic          ls_q;

      // Idle count: cleared by an access or a wake request, otherwise saturating up-count.
      always_comb begin
        cnt_n = cnt_q;
        if (cs[k] || (ls_q && req_any[k])) cnt_n = '0;
        else if (cnt_q != CW'(IDLE_LS))    cnt_n = cnt_q + 1'b1;
      end

      // Idle counter and light-sleep flag registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          ls_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_n;
          ls_q  <= (cnt_n == CW'(IDLE_LS));
        end
      end

      assign ls_status[k] = ls_q;
    end
  end else begin : g_no_ls
    assign ls_status = '0;
  end

endmodule

// File: doc/e203_itcm_banked_ram.md
Name: e203_itcm_banked_ram

Overview:
Parametrised ITCM storage built from NBANK interleaved sirv_gnrl_ram banks.
- Two independent request ports: port A for IFU fetch, port B for LSU access.
- Valid/ready command and response channels on each port.
- Per-bank round-robin arbitration.
- Registered responses with 1-cycle latency.
- Automatic per-bank light-sleep entry after a configurable idle period, with a 1-cycle wake.
- Successor to the single-port ITCM RAM wrapper; sits between the ITCM controller and the physical banks.

Parameters:
AW, 16, word address width (total across all banks)
DW, 64, data width
MW, 8, write-mask width (DW/MW bits per mask bit)
NBANK, 2, bank count; power of 2, at least 1; bank select is addr[log2(NBANK)-1:0]
IDLE_LS, 16, idle cycles before a bank enters light sleep; 0 disables auto-ls

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sd  in  1  global shutdown, forwarded to all banks
ds  in  1  global deep-sleep, forwarded to all banks
a_cmd_valid  in  1  port A request valid
a_cmd_ready  out  1  port A request accepted
a_cmd_read  in  1  1 = read, 0 = write
a_cmd_addr  in  AW  word address
a_cmd_wdata  in  DW  write data
a_cmd_wmask  in  MW  write byte-lane mask
a_rsp_valid  out  1  port A response valid
a_rsp_ready  in  1  port A response accepted
a_rsp_rdata  out  DW  read data; 0 for write responses
b_*  (same set as a_*)  port B equivalents
ls_status  out  NBANK  per-bank light-sleep state

Behaviour:
- Reset values (async, rst_n=0):
  - *_rsp_valid=0, *_rsp_rdata=0, ls_status=0.
  - Idle counters=0; all round-robin pointers favour B.
- Address mapping:
  - Bank index k = addr[log2(NBANK)-1:0].
  - Bank row = addr[AW-1:log2(NBANK)]; bank depth = 2^(AW-log2(NBANK)).
  - NBANK=1: no bank bits.
- Port slot free: rsp_valid=0, or rsp_valid=1 and rsp_ready=1 in the same cycle.
- Port ready requires all of:
  - sd=0;
  - the port's slot is free;
  - target bank ls_status[k]=0;
  - the port holds the grant for bank k.
- Ready is combinational from valid/addr; it does not depend on ready of the other port.
- Arbitration:
  - Different banks: both ports granted in the same cycle.
  - Same bank, both requesting: the port favoured by pointer[k] wins.
  - pointer[k] flips to the other port only after a conflicted grant to bank k.
  - A request on one port blocked for its own reasons (slot full, sleep) does not create a conflict; the other port is granted.
- Access:
  - On accept, bank k sees cs=1 and we=~read, with addr row, din, and wem=wmask.
- Response:
  - rsp_valid rises the cycle after accept.
  - Read: rdata = bank dout captured into the port holding register.
  - Write: rdata = 0.
  - rsp_valid and rdata hold stable until rsp_ready=1.
  - Back-to-back accepts with rsp_ready held high give 1 response per cycle.
- Light sleep (IDLE_LS>0):
  - Per-bank counter resets to 0 on any accept to the bank.
  - Otherwise it increments, saturating at IDLE_LS.
  - ls_status[k] sets when the counter reaches IDLE_LS; it drives bank ls.
  - A valid request from either port to a sleeping bank clears ls_status[k] next cycle and resets the counter.
  - Ready is 0 during the wake cycle, so the earliest accept is 1 cycle after ls_status falls.
- Shutdown:
  - sd=1 forces all ready=0.
  - Already-registered responses are still delivered.
  - Bank contents after sd are undefined.
  - ls_status and counters are unaffected.
- Deep sleep: ds is forwarded to all banks and does not gate ready; the system guarantees no traffic while ds=1.
- Reset mid-operation: pending responses are discarded; no response is emitted after reset release without a new accept.

Test Plan:
1. Reset, then A writes addr 0x0004 with wdata 0x1122334455667788 and wmask 0xFF; A then reads 0x0004 -> a_rsp_valid exactly 1 cycle after each accept; read rdata=0x1122334455667788; write rsp rdata=0.
2. NBANK=2: A reads 0x0010 and B reads 0x0011 in the same cycle -> both ready=1; both rsp the next cycle.
3. A and B both read 0x0020, held valid for 3 cycles -> grants B, A, B (pointer reset favours B); each response 1 cycle after its grant.
4. Read accepted with a_rsp_ready=0 for 4 cycles -> rsp_valid and rdata stable; a_cmd_ready=0 until the cycle rsp_ready=1.
5. IDLE_LS=16, bank 1 idle 16 cycles -> ls_status=2'b10; B read 0x0003 -> ready=0 for 1 cycle, ls_status falls, accept 1 cycle later, rsp the cycle after.
6. sd=1 with both ports valid -> ready=0 on both; an outstanding rsp completes; rst_n pulsed with rsp pending -> rsp_valid=0 and no response after release.
